// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: samples hs/vs/RGB, recovers x/y/de/pix two clocks later,
// verifies line, frame and sync-width timing and tracks lock.
module vga_sync_decoder #(
    parameter int h_res    = 640,
    parameter int v_res    = 480,
    parameter int h_t_fp   = 16,
    parameter int h_t_pw   = 96,
    parameter int h_t_bp   = 48,
    parameter int v_t_fp   = 10,
    parameter int v_t_pw   = 2,
    parameter int v_t_bp   = 33,
    parameter bit sync_pol = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [2:0]  RED,
    input  logic [2:0]  GREEN,
    input  logic [1:0]  BLUE,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [7:0]  pix,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int H_TOTAL = h_res + h_t_fp + h_t_pw + h_t_bp;
    localparam int V_TOTAL = v_res + v_t_fp + v_t_pw + v_t_bp;

    localparam logic [11:0] H_TOT_M1  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_TOT_M1  = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_PW      = 12'(h_t_pw);
    localparam logic [11:0] V_PW      = 12'(v_t_pw);
    localparam logic [11:0] H_ACT_LO  = 12'(h_t_pw + h_t_bp);
    localparam logic [11:0] H_ACT_HI  = 12'(h_t_pw + h_t_bp + h_res - 1);
    localparam logic [11:0] V_ACT_LO  = 12'(v_t_pw + v_t_bp);
    localparam logic [11:0] V_ACT_HI  = 12'(v_t_pw + v_t_bp + v_res - 1);
    localparam logic [1:0]  GOOD_NEED = 2'd2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       w_hs_n;
    logic       w_vs_n;
    logic       r_hs_p0;
    logic       r_vs_p0;
    logic       r_vld_p0;
    logic       r_hs_d;
    logic       r_vs_d;
    logic       r_vld_d;
    logic [7:0] r_rgb_p0;

    assign w_hs_n = sync_pol ? hs : ~hs;
    assign w_vs_n = sync_pol ? vs : ~vs;

    // ---- stage 1: sample syncs (normalised active-high) and pixel ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_p0  <= 1'b0;
            r_vs_p0  <= 1'b0;
            r_vld_p0 <= 1'b0;
            r_hs_d   <= 1'b0;
            r_vs_d   <= 1'b0;
            r_vld_d  <= 1'b0;
        end else begin
            r_hs_p0  <= w_hs_n;
            r_vs_p0  <= w_vs_n;
            r_vld_p0 <= 1'b1;
            r_hs_d   <= r_hs_p0;
            r_vs_d   <= r_vs_p0;
            r_vld_d  <= r_vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        r_rgb_p0 <= {RED, GREEN, BLUE};
    end

    // Edges need two real samples, so a sync already asserted at reset release is not an edge.
    logic w_edge_ok;
    logic w_hs_rise;
    logic w_hs_fall;
    logic w_vs_fall;

    assign w_edge_ok = r_vld_p0 & r_vld_d;
    assign w_hs_rise = w_edge_ok & r_hs_p0 & ~r_hs_d;
    assign w_hs_fall = w_edge_ok & ~r_hs_p0 & r_hs_d;
    assign w_vs_fall = w_edge_ok & ~r_vs_p0 & r_vs_d;

    logic [11:0] r_hcnt;
    logic [11:0] r_pwcnt;
    logic [11:0] r_lcnt;
    logic [11:0] r_vspw;
    logic        r_vs_ln;
    logic        r_h_seen;
    logic        r_v_seen;

    logic [11:0] w_hcnt_nxt;
    logic [11:0] w_pwcnt_nxt;
    logic [11:0] w_lcnt_nxt;
    logic [11:0] w_vspw_nxt;
    logic        w_fs;

    assign w_fs        = w_hs_rise & r_h_seen & r_vs_p0 & ~r_vs_ln;
    assign w_hcnt_nxt  = w_hs_rise ? 12'd0 : sat_inc12(r_hcnt);
    assign w_pwcnt_nxt = w_hs_rise ? 12'd1 : (r_hs_p0 ? sat_inc12(r_pwcnt) : r_pwcnt);
    assign w_lcnt_nxt  = w_fs ? 12'd0 : (w_hs_rise ? sat_inc12(r_lcnt) : r_lcnt);
    assign w_vspw_nxt  = w_fs ? 12'd1 :
                         ((w_hs_rise & r_vs_p0) ? sat_inc12(r_vspw) : r_vspw);

    logic w_err_line;
    logic w_err_hpw;
    logic w_err_frame;
    logic w_err_vpw;
    logic w_err_any;

    assign w_err_line  = w_hs_rise & r_h_seen & (r_hcnt != H_TOT_M1);
    assign w_err_hpw   = w_hs_fall & r_h_seen & (r_pwcnt != H_PW);
    assign w_err_frame = w_fs & r_v_seen & (r_lcnt != V_TOT_M1);
    assign w_err_vpw   = w_vs_fall & r_v_seen & (r_vspw != V_PW);
    assign w_err_any   = w_err_line | w_err_hpw | w_err_frame | w_err_vpw;

    // ---- stage 2: timing counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt   <= 12'd0;
            r_pwcnt  <= 12'd0;
            r_lcnt   <= 12'd0;
            r_vspw   <= 12'd0;
            r_vs_ln  <= 1'b0;
            r_h_seen <= 1'b0;
            r_v_seen <= 1'b0;
        end else begin
            r_hcnt  <= w_hcnt_nxt;
            r_pwcnt <= w_pwcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_vspw  <= w_vspw_nxt;
            if (w_hs_rise) begin
                r_vs_ln  <= r_vs_p0;
                r_h_seen <= 1'b1;
            end
            if (w_fs) begin
                r_v_seen <= 1'b1;
            end
        end
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_good;
    logic [1:0] w_good_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEARCH;
            r_good  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    // An error always wins over a coincident frame_start and restarts the clean-frame count.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        if (w_err_any) begin
            w_state_nxt = SEARCH;
            w_good_nxt  = 2'd0;
        end else if (w_fs) begin
            case (r_state)
                SEARCH: begin
                    w_state_nxt = VERIFY;
                    w_good_nxt  = 2'd0;
                end
                VERIFY: begin
                    if (r_good == GOOD_NEED - 2'd1) begin
                        w_state_nxt = LOCKED;
                        w_good_nxt  = 2'd0;
                    end else begin
                        w_good_nxt = r_good + 2'd1;
                    end
                end
                LOCKED:  w_state_nxt = LOCKED;
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (r_state == LOCKED);
    end

    // de follows the next lock state so it tracks locked in the same output cycle.
    logic w_act;
    logic w_de;

    assign w_act = (w_hcnt_nxt >= H_ACT_LO) && (w_hcnt_nxt <= H_ACT_HI) &&
                   (w_lcnt_nxt >= V_ACT_LO) && (w_lcnt_nxt <= V_ACT_HI);
    assign w_de  = w_act && (w_state_nxt == LOCKED);

    logic        r_de_p1;
    logic [11:0] r_x_p1;
    logic [11:0] r_y_p1;
    logic [7:0]  r_pix_p1;
    logic        r_fs_p1;
    logic        r_err_p1;
    logic [7:0]  r_err_cnt;

    // ---- stage 2: output registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de_p1   <= 1'b0;
            r_x_p1    <= 12'd0;
            r_y_p1    <= 12'd0;
            r_pix_p1  <= 8'd0;
            r_fs_p1   <= 1'b0;
            r_err_p1  <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_de_p1  <= w_de;
            r_x_p1   <= w_de ? (w_hcnt_nxt - H_ACT_LO) : 12'd0;
            r_y_p1   <= w_de ? (w_lcnt_nxt - V_ACT_LO) : 12'd0;
            r_pix_p1 <= w_de ? r_rgb_p0 : 8'd0;
            r_fs_p1  <= w_fs;
            r_err_p1 <= w_err_any;
            if (w_err_any) begin
                r_err_cnt <= sat_inc8(r_err_cnt);
            end
        end
    end

    assign de          = r_de_p1;
    assign x           = r_x_p1;
    assign y           = r_y_p1;
    assign pix         = r_pix_p1;
    assign frame_start = r_fs_p1;
    assign err         = r_err_p1;
    assign err_cnt     = r_err_cnt;

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. Samples `hs`, `vs` and 8-bit RGB at the pixel clock and recovers pixel coordinates, a data-enable and the pixel value. Checks every line and frame against the configured timing and reports lock and timing errors. Used as a loop-back checker on the generator output and as the capture front-end for downstream pixel processing.

## Interface
- `h_res`, 640: active pixels per line
- `v_res`, 480: active lines per frame
- `h_t_fp`, 16: horizontal front porch, in pixel clocks
- `h_t_pw`, 96: hsync pulse width, in pixel clocks
- `h_t_bp`, 48: horizontal back porch, in pixel clocks
- `v_t_fp`, 10: vertical front porch, in lines
- `v_t_pw`, 2: vsync pulse width, in lines
- `v_t_bp`, 33: vertical back porch, in lines
- `sync_pol`, 0: sync polarity; 0 = active-low, 1 = active-high
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `hs`  in  1  horizontal sync
- `vs`  in  1  vertical sync
- `RED`  in  3  red component
- `GREEN`  in  3  green component
- `BLUE`  in  2  blue component
- `de`  out  1  active pixel valid; gated by `locked`
- `x`  out  12  active pixel column, 0..h_res-1; 0 when `de`=0
- `y`  out  12  active pixel row, 0..v_res-1; 0 when `de`=0
- `pix`  out  8  {RED,GREEN,BLUE} of the current pixel; 0 when `de`=0
- `frame_start`  out  1  one-cycle pulse at vsync leading edge (line 0)
- `locked`  out  1  timing verified
- `err`  out  1  one-cycle pulse on any timing mismatch
- `err_cnt`  out  8  error count, saturates at 255

## Operation
- Derived constants: h_total = h_res+h_t_fp+h_t_pw+h_t_bp; v_total = v_res+v_t_fp+v_t_pw+v_t_bp.
- Stage 1 registers `hs`, `vs` and RGB. Syncs are normalised to active-high using `sync_pol`.
- Edge detection runs on the stage-1 values.
- hcnt:
  - Set to 0 on the cycle the normalised hs is first seen asserted (hs leading edge); +1 otherwise.
  - Saturates at 4095.
- pwcnt: counts cycles with hs asserted. Checked against h_t_pw at the hs trailing edge.
- Line check: at each hs leading edge after the first one since reset, the previous line length is hcnt+1. It must equal h_total.
- lcnt, updated at each hs leading edge:
  - If vs is asserted and was deasserted at the previous hs leading edge, then lcnt←0 and `frame_start` pulses.
  - Otherwise lcnt←lcnt+1.
- Frame check: at `frame_start`, after the first one since reset, the previous lcnt+1 must equal v_total. The vs line count is checked against v_t_pw at the vs trailing edge.
- Active region:
  - Columns: hcnt ∈ [h_t_pw+h_t_bp, h_t_pw+h_t_bp+h_res-1].
  - Rows: lcnt ∈ [v_t_pw+v_t_bp, v_t_pw+v_t_bp+v_res-1].
  - x = hcnt-(h_t_pw+h_t_bp); y = lcnt-(v_t_pw+v_t_bp).
- Lock FSM, states SEARCH, VERIFY, LOCKED:
  - SEARCH→VERIFY on the first `frame_start`.
  - VERIFY→LOCKED at the `frame_start` that closes 2 consecutive error-free complete frames.
  - Any error in any state → SEARCH, `locked`←0.
  - Counting restarts from that point.
- On any mismatch:
  - `err` pulses one cycle.
  - `err_cnt` increments, saturating at 255.
  - Simultaneous mismatches in one cycle count as one error.
- Reset mid-operation: all state is cleared and the FSM goes to SEARCH. The partial line and frame following reset are not checked.

## Timing
- Reset values: `de`, `x`, `y`, `pix`, `frame_start`, `locked`, `err`, `err_cnt` are all 0. FSM = SEARCH.
- Latency: 2 cycles.
  - A pixel sampled at cycle t appears on `pix` at t+2, with its `x`/`y`/`de` aligned.
  - `frame_start`, `err` and `locked` updates use the same 2-cycle alignment relative to the causing sync edge.
- `de` is high exactly h_res consecutive cycles per active line and v_res lines per frame, only while `locked`=1.
- `locked` rises in the same cycle as the qualifying `frame_start`. The first active pixel of that frame is output with `de`=1.

## Test plan
Generator parameters: h_res 16, v_res 9, h_t_fp 2, h_t_pw 3, h_t_bp 1, v_t_fp 5, v_t_pw 2, v_t_bp 7, so h_total = 22, v_total = 23 and one frame = 506 clocks.

- **Reset values:** `rst` pulse mid-stream → all outputs 0 on the next cycle; `locked` stays low until 2 full frames after the next `frame_start`.
- **Nominal lock:** clean generator stream → `frame_start` every 506 clocks; `locked`=1 at the 3rd `frame_start`; `err_cnt`=0.
- **Coordinates and pixel data:** RGB driven with hcnt[7:0] →
  - `de` is high 16 cycles per line on 9 lines.
  - First pixel: x=0, y=0, `pix`=4.
  - Last pixel: x=15, y=8, `pix`=19.
  - Every pixel is output 2 cycles after its input.
- **Long line:** one line stretched to 23 clocks → `err` pulses once, `locked`→0, `err_cnt`=1; relock after 2 further clean frames.
- **Bad vsync width:** vs held for 3 lines → `err` at the vs trailing edge; `err_cnt` increments by 1.
- **Polarity and saturation:** `sync_pol`=1 with inverted syncs → identical lock behaviour. 300 forced mismatches → `err_cnt` holds at 255.
